// File: rtl/bcd_updown_counter.sv
// Two-digit BCD up/down counter with an enable-gated prescaler, a synchronous
// load that clamps digits above 9, and a terminal-count pulse on wrap.
module bcd_updown_counter #(
  parameter int unsigned DIV = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       EN,
  input  logic       UP,
  input  logic       LOAD,
  input  logic [3:0] LD_T,
  input  logic [3:0] LD_U,
  output logic       U3,
  output logic       U2,
  output logic       U1,
  output logic       U0,
  output logic       T3,
  output logic       T2,
  output logic       T1,
  output logic       T0,
  output logic       TC,
  output logic       LDERR
);

  localparam logic [7:0] LP_LAST = 8'(DIV - 1);

  logic [7:0] r_presc;
  logic [3:0] r_units;
  logic [3:0] r_tens;
  logic       r_tc;
  logic       r_lderr;

  logic       w_step;
  logic       w_wrap;
  logic       w_ld_bad;
  logic [3:0] w_ld_t;
  logic [3:0] w_ld_u;
  logic [3:0] w_units_nx;
  logic [3:0] w_tens_nx;

  always_comb begin
    w_step     = EN && (r_presc == LP_LAST);
    w_ld_t     = (LD_T > 4'd9) ? 4'd9 : LD_T;
    w_ld_u     = (LD_U > 4'd9) ? 4'd9 : LD_U;
    w_ld_bad   = (LD_T > 4'd9) || (LD_U > 4'd9);
    w_wrap     = 1'b0;
    w_units_nx = r_units;
    w_tens_nx  = r_tens;
    if (UP) begin
      w_wrap = (r_tens == 4'd9) && (r_units == 4'd9);
      if (r_units == 4'd9) begin
        w_units_nx = 4'd0;
        w_tens_nx  = (r_tens == 4'd9) ? 4'd0 : r_tens + 4'd1;
      end else begin
        w_units_nx = r_units + 4'd1;
      end
    end else begin
      w_wrap = (r_tens == 4'd0) && (r_units == 4'd0);
      if (r_units == 4'd0) begin
        w_units_nx = 4'd9;
        w_tens_nx  = (r_tens == 4'd0) ? 4'd9 : r_tens - 4'd1;
      end else begin
        w_units_nx = r_units - 4'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_presc <= '0;
      r_units <= '0;
      r_tens  <= '0;
      r_tc    <= 1'b0;
      r_lderr <= 1'b0;
    end else if (LOAD) begin
      // Load wins over counting: prescaler restarts, no step, no TC.
      r_presc <= '0;
      r_units <= w_ld_u;
      r_tens  <= w_ld_t;
      r_tc    <= 1'b0;
      r_lderr <= w_ld_bad;
    end else begin
      r_lderr <= 1'b0;
      r_tc    <= w_step && w_wrap;
      if (EN) begin
        r_presc <= w_step ? '0 : r_presc + 8'd1;
      end
      if (w_step) begin
        r_units <= w_units_nx;
        r_tens  <= w_tens_nx;
      end
    end
  end

  assign {U3, U2, U1, U0} = r_units;
  assign {T3, T2, T1, T0} = r_tens;
  assign TC               = r_tc;
  assign LDERR            = r_lderr;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench: a vector table on a DIV=1 counter plus hand sequences for
// full-range counting, prescaler stretching (DIV=4) and mid-run reset (DIV=3).
module tb_bcd_updown_counter;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       EN, UP, LOAD;
  logic [3:0] LD_T, LD_U;

  logic a_u3, a_u2, a_u1, a_u0, a_t3, a_t2, a_t1, a_t0, a_tc, a_le;
  logic b_u3, b_u2, b_u1, b_u0, b_t3, b_t2, b_t1, b_t0, b_tc, b_le;
  logic c_u3, c_u2, c_u1, c_u0, c_t3, c_t2, c_t1, c_t0, c_tc, c_le;

  // packed view: {tens, units, tc, lderr}
  logic [9:0] o1, o4, o3;
  assign o1 = {a_t3, a_t2, a_t1, a_t0, a_u3, a_u2, a_u1, a_u0, a_tc, a_le};
  assign o4 = {b_t3, b_t2, b_t1, b_t0, b_u3, b_u2, b_u1, b_u0, b_tc, b_le};
  assign o3 = {c_t3, c_t2, c_t1, c_t0, c_u3, c_u2, c_u1, c_u0, c_tc, c_le};

  bcd_updown_counter #(.DIV(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .UP(UP), .LOAD(LOAD), .LD_T(LD_T), .LD_U(LD_U),
    .U3(a_u3), .U2(a_u2), .U1(a_u1), .U0(a_u0), .T3(a_t3), .T2(a_t2), .T1(a_t1), .T0(a_t0),
    .TC(a_tc), .LDERR(a_le));

  bcd_updown_counter #(.DIV(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .UP(UP), .LOAD(LOAD), .LD_T(LD_T), .LD_U(LD_U),
    .U3(b_u3), .U2(b_u2), .U1(b_u1), .U0(b_u0), .T3(b_t3), .T2(b_t2), .T1(b_t1), .T0(b_t0),
    .TC(b_tc), .LDERR(b_le));

  bcd_updown_counter #(.DIV(3)) dut3 (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .UP(UP), .LOAD(LOAD), .LD_T(LD_T), .LD_U(LD_U),
    .U3(c_u3), .U2(c_u2), .U1(c_u1), .U0(c_u0), .T3(c_t3), .T2(c_t2), .T1(c_t1), .T0(c_t0),
    .TC(c_tc), .LDERR(c_le));

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       load;
    logic       en;
    logic       up;
    logic [3:0] ld_t;
    logic [3:0] ld_u;
    logic [3:0] e_t;
    logic [3:0] e_u;
    logic       e_tc;
    logic       e_le;
  } vec_t;

  vec_t vt [20];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got T=%h U=%h TC=%b LDERR=%b, want T=%h U=%h TC=%b LDERR=%b",
                  name, act[9:6], act[5:2], act[1], act[0], exp[9:6], exp[5:2], exp[1], exp[0]);
  endtask

  // one clock edge, then settle away from it
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic ld, input logic en, input logic up,
                       input logic [3:0] lt, input logic [3:0] lu);
    LOAD = ld; EN = en; UP = up; LD_T = lt; LD_U = lu;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    vt[0]  = '{1'b1, 1'b0, 1'b1, 4'd3,  4'd7,  4'd3, 4'd7, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 1'b1, 4'd0,  4'd0,  4'd3, 4'd8, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 1'b1, 4'd0,  4'd0,  4'd3, 4'd9, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 1'b1, 4'd0,  4'd0,  4'd4, 4'd0, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  4'd4, 4'd0, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd0,  4'd3, 4'd9, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd0,  4'd3, 4'd8, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 1'b1, 1'b1, 4'd12, 4'd5,  4'd9, 4'd5, 1'b0, 1'b1};
    vt[8]  = '{1'b0, 1'b1, 1'b1, 4'd0,  4'd0,  4'd9, 4'd6, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 4'd0,  4'd0,  4'd0, 4'd0, 1'b0, 1'b0};
    vt[10] = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd0,  4'd9, 4'd9, 1'b1, 1'b0};
    vt[11] = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd0,  4'd9, 4'd8, 1'b0, 1'b0};
    vt[12] = '{1'b1, 1'b0, 1'b1, 4'd9,  4'd9,  4'd9, 4'd9, 1'b0, 1'b0};
    vt[13] = '{1'b0, 1'b1, 1'b1, 4'd0,  4'd0,  4'd0, 4'd0, 1'b1, 1'b0};
    vt[14] = '{1'b0, 1'b1, 1'b1, 4'd0,  4'd0,  4'd0, 4'd1, 1'b0, 1'b0};
    vt[15] = '{1'b1, 1'b1, 1'b1, 4'd9,  4'd9,  4'd9, 4'd9, 1'b0, 1'b0};
    vt[16] = '{1'b1, 1'b1, 1'b1, 4'd4,  4'd2,  4'd4, 4'd2, 1'b0, 1'b0};
    vt[17] = '{1'b1, 1'b0, 1'b0, 4'd15, 4'd15, 4'd9, 4'd9, 1'b0, 1'b1};
    vt[18] = '{1'b1, 1'b1, 1'b0, 4'd0,  4'd10, 4'd0, 4'd9, 1'b0, 1'b1};
    vt[19] = '{1'b0, 1'b0, 1'b1, 4'd0,  4'd0,  4'd0, 4'd9, 1'b0, 1'b0};

    // reset asserted before any clock edge
    RST_N = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    #2;
    chk("reset_div1", o1, 10'd0);
    chk("reset_div4", o4, 10'd0);
    chk("reset_div3", o3, 10'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // vector table on the DIV=1 counter
    for (int i = 0; i < 20; i++) begin
      drive(vt[i].load, vt[i].en, vt[i].up, vt[i].ld_t, vt[i].ld_u);
      tick();
      chk($sformatf("vec%0d", i), o1, {vt[i].e_t, vt[i].e_u, vt[i].e_tc, vt[i].e_le});
    end

    // full up-count 00..99..00 from reset
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 4'd0, 4'd0);
    for (int i = 1; i <= 100; i++) begin
      int unsigned v;
      v = i % 100;
      tick();
      chk($sformatf("count%0d", i), o1,
          {4'(v / 10), 4'(v % 10), (i == 100), 1'b0});
    end

    // DIV=4: steps every 4th enabled edge; 2 disabled edges stretch to 6
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 4'd0, 4'd0);
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk($sformatf("div4_e%0d", e), o4, {4'd0, 4'(e / 4), 2'b00});
    end
    drive(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    tick(); chk("div4_hold1", o4, {4'd0, 4'd2, 2'b00});
    tick(); chk("div4_hold2", o4, {4'd0, 4'd2, 2'b00});
    drive(1'b0, 1'b1, 1'b1, 4'd0, 4'd0);
    tick(); chk("div4_e13", o4, {4'd0, 4'd2, 2'b00});
    tick(); chk("div4_e14", o4, {4'd0, 4'd3, 2'b00});

    // DIV=3: reset between edges with prescaler at 2 and value 57
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 4'd5, 4'd7);
    tick(); chk("div3_load", o3, {4'd5, 4'd7, 2'b00});
    drive(1'b0, 1'b1, 1'b1, 4'd0, 4'd0);
    tick(); tick();
    chk("div3_pre2", o3, {4'd5, 4'd7, 2'b00});
    #3;
    RST_N = 1'b0;
    #1;
    chk("div3_async", o3, 10'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    tick(); chk("div3_r1", o3, 10'd0);
    tick(); chk("div3_r2", o3, 10'd0);
    tick(); chk("div3_r3", o3, {4'd0, 4'd1, 2'b00});

    // TC and LDERR pulses are killed by reset and do not reappear
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 4'd9, 4'd9);
    tick();
    drive(1'b0, 1'b1, 1'b1, 4'd0, 4'd0);
    tick(); chk("tc_before_rst", o1, {4'd0, 4'd0, 2'b10});
    #2;
    RST_N = 1'b0;
    #1;
    chk("tc_abort", o1, 10'd0);
    drive(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    tick(); chk("tc_after_rel", o1, 10'd0);
    drive(1'b1, 1'b0, 1'b1, 4'd11, 4'd2);
    tick(); chk("le_before_rst", o1, {4'd9, 4'd2, 2'b01});
    #2;
    RST_N = 1'b0;
    #1;
    chk("le_abort", o1, 10'd0);
    drive(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    tick(); chk("le_after_rel", o1, 10'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 SHALL provide parameter DIV, default 1, meaning enabled clock cycles per count step (legal range 1..255).
REQ-002 SHALL provide port CLK  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL provide port RST_N  input  1  reset, asynchronous and active-low.
REQ-004 SHALL provide port EN  input  1  count enable; prescaler advances only while high.
REQ-005 SHALL provide port UP  input  1  direction: 1 = increment, 0 = decrement.
REQ-006 SHALL provide port LOAD  input  1  synchronous load strobe.
REQ-007 SHALL provide port LD_T  input  4  BCD tens digit to load.
REQ-008 SHALL provide port LD_U  input  4  BCD units digit to load.
REQ-009 SHALL provide ports U3,U2,U1,U0  output  1 each  registered units digit, MSB..LSB; drives the decimal decoder A3..A0 directly.
REQ-010 SHALL provide ports T3,T2,T1,T0  output  1 each  registered tens digit, MSB..LSB.
REQ-011 SHALL provide port TC  output  1  terminal-count pulse on wrap.
REQ-012 SHALL provide port LDERR  output  1  pulse flagging an out-of-range load digit.

Function
REQ-013 SHALL hold a two-digit BCD value 00..99; each digit never leaves 0..9.
REQ-014 SHALL run a prescaler 0..DIV-1 that increments on each edge with EN=1 and holds with EN=0.
REQ-015 SHALL generate an internal step on the edge where EN=1 and prescaler = DIV-1; the prescaler returns to 0 on that edge.
REQ-016 SHALL, with DIV=1, step on every edge with EN=1.
REQ-017 SHALL, on a step with UP=1: units+1; units 9 -> 0 with tens+1; 99 -> 00.
REQ-018 SHALL, on a step with UP=0: units-1; units 0 -> 9 with tens-1; 00 -> 99.
REQ-019 SHALL update U*/T* on the same edge as the step (zero added latency; outputs are flops).
REQ-020 SHALL assert TC for exactly one cycle, registered on the edge of a 99->00 (up) or 00->99 (down) wrap; TC=0 otherwise.
REQ-021 SHALL sample UP only at step edges; a UP change between steps takes effect at the next step.
REQ-022 SHALL, when LOAD=1 on an edge, load LD_T/LD_U, clear the prescaler, suppress any step on that edge, and hold TC=0.
REQ-023 SHALL give LOAD priority over EN and UP.
REQ-024 SHALL replace any loaded digit > 9 (10..15) by 9 and assert LDERR for exactly that one cycle after the load edge; LDERR=0 otherwise.
REQ-025 SHALL treat LOAD with EN=0 identically to LOAD with EN=1.
REQ-026 SHALL keep value and prescaler unchanged on edges with EN=0 and LOAD=0.

Reset
REQ-027 SHALL, while RST_N=0, force immediately (no clock needed): U*=0, T*=0, prescaler=0, TC=0, LDERR=0.
REQ-028 SHALL, after RST_N rises, take no step until DIV further edges with EN=1 have occurred.
REQ-029 SHALL abort any pending step or TC/LDERR pulse when reset asserts mid-operation; no pulse appears after release.

Verification
REQ-030 DIV=1, EN=1, UP=1 from reset for 100 edges -> 00,01..09,10..99,00; TC high only in the cycle showing 00 after 99.
REQ-031 DIV=1, LOAD with LD_T=0, LD_U=0, then UP=0, EN=1 for 1 edge -> value 99, TC=1 for one cycle; next edge 98, TC=0.
REQ-032 DIV=4, EN=1, UP=1 from 00 -> value changes only every 4th edge (01 at edge 4, 02 at edge 8); EN low 2 cycles mid-interval stretches the interval to 6 edges.
REQ-033 LOAD with LD_T=12, LD_U=5 -> value 95, LDERR=1 one cycle; LOAD with LD_T=3, LD_U=7 -> 37, LDERR=0.
REQ-034 Value 99, UP=1, EN=1, LOAD=1 with 42 on same edge -> value 42, TC stays 0.
REQ-035 Value 57 with DIV=3 prescaler at 2, RST_N pulsed low between edges -> outputs 00 immediately, TC=0; first step after release needs 3 enabled edges.
